// File: rtl/data_ram.sv
// Word-wide data memory for the CPU data port: same-cycle reads, edge-committed writes,
// a sticky first-fault recorder and saturating read/write access counters.
`timescale 1ns/1ps
module data_ram #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memCe,
    input  logic             memWr,
    input  logic [31:0]      memAddr,
    input  logic [31:0]      wtData,
    output logic [31:0]      rdData,
    output logic             memErr,
    output logic [31:0]      errAddr,
    input  logic             errClr,
    output logic [CNT_W-1:0] rdCnt,
    output logic [CNT_W-1:0] wrCnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FAULT = 1'b1
    } err_state_e;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              aligned;
    logic              ok;
    logic              fault;
    logic              rd_ok;
    logic              wr_ok;

    err_state_e        state_q, state_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // BASE_ADDR is DEPTH*4 aligned, so off[1:0] equals memAddr[1:0].
    assign off      = memAddr - BASE_ADDR;
    assign idx      = off[ADDR_W+1:2];
    assign in_range = (off[31:ADDR_W+2] == '0);
    assign aligned  = (off[1:0] == 2'b00);
    assign ok       = memCe & in_range & aligned;
    assign fault    = memCe & ~(in_range & aligned);
    assign rd_ok    = ok & ~memWr;
    assign wr_ok    = ok & memWr;

    always_comb begin
        rdData = '0;
        if (!rst && rd_ok) begin
            rdData = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[idx] <= wtData;
        end
    end

    // A fault always wins over a simultaneous clear; otherwise only the first fault is kept.
    always_comb begin
        state_d    = state_q;
        err_addr_d = err_addr_q;
        case (state_q)
            IDLE: begin
                if (fault) begin
                    state_d    = FAULT;
                    err_addr_d = memAddr;
                end else if (errClr) begin
                    err_addr_d = '0;
                end
            end
            FAULT: begin
                if (fault && errClr) begin
                    err_addr_d = memAddr;
                end else if (errClr) begin
                    state_d    = IDLE;
                    err_addr_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                err_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_ok) begin
            rd_cnt_d = sat_inc(rd_cnt_q);
        end
        if (wr_ok) begin
            wr_cnt_d = sat_inc(wr_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign memErr  = (state_q == FAULT);
    assign errAddr = err_addr_q;
    assign rdCnt   = rd_cnt_q;
    assign wrCnt   = wr_cnt_q;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: two instances (base 0 / 16-bit counters and base 0x1000_0000 / 4-bit
// counters) driven in parallel, checked by a vector table, directed sequences and a random model.
`timescale 1ns/1ps
module tb_data_ram;

    logic        clk = 1'b0;
    logic        rst, memCe, memWr, errClr;
    logic [31:0] memAddr, wtData;

    logic [31:0] rdData0, errAddr0, rdData1, errAddr1;
    logic        memErr0, memErr1;
    logic [15:0] rdCnt0, wrCnt0;
    logic [3:0]  rdCnt1, wrCnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_ram #(.ADDR_W(10), .BASE_ADDR(32'h0000_0000), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .memCe(memCe), .memWr(memWr), .memAddr(memAddr),
        .wtData(wtData), .rdData(rdData0), .memErr(memErr0), .errAddr(errAddr0),
        .errClr(errClr), .rdCnt(rdCnt0), .wrCnt(wrCnt0));

    data_ram #(.ADDR_W(10), .BASE_ADDR(32'h1000_0000), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .memCe(memCe), .memWr(memWr), .memAddr(memAddr),
        .wtData(wtData), .rdData(rdData1), .memErr(memErr1), .errAddr(errAddr1),
        .errClr(errClr), .rdCnt(rdCnt1), .wrCnt(wrCnt1));

    // Reference model: a plain word array per instance plus error and counter bookkeeping.
    logic [31:0] mm [2][1024];
    logic        m_err [2];
    logic [31:0] m_eaddr [2];
    int          m_rc [2];
    int          m_wc [2];
    logic [31:0] m_base [2] = '{32'h0000_0000, 32'h1000_0000};
    int          m_max [2] = '{65535, 15};
    logic [31:0] rd0_seen;

    function automatic bit m_ok(int k, logic [31:0] a);
        logic [31:0] off;
        off = a - m_base[k];
        return (off < 32'd4096) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] m_rd(int k);
        if (rst || !memCe || memWr || !m_ok(k, memAddr)) return 32'h0;
        return mm[k][(memAddr - m_base[k]) / 4];
    endfunction

    task automatic m_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 1024; i++) mm[k][i] = 32'h0;
                m_err[k] = 1'b0; m_eaddr[k] = 32'h0; m_rc[k] = 0; m_wc[k] = 0;
            end else begin
                if (memCe && m_ok(k, memAddr)) begin
                    if (memWr) begin
                        mm[k][(memAddr - m_base[k]) / 4] = wtData;
                        if (m_wc[k] < m_max[k]) m_wc[k]++;
                    end else if (m_rc[k] < m_max[k]) begin
                        m_rc[k]++;
                    end
                end
                if (memCe && !m_ok(k, memAddr) && (!m_err[k] || errClr)) begin
                    m_err[k] = 1'b1; m_eaddr[k] = memAddr;
                end else if (errClr) begin
                    m_err[k] = 1'b0; m_eaddr[k] = 32'h0;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; both instances are compared against the model every cycle.
    task automatic step(input logic r, input logic ce, input logic wr, input logic clr,
                        input logic [31:0] a, input logic [31:0] d);
        rst = r; memCe = ce; memWr = wr; errClr = clr; memAddr = a; wtData = d;
        #1;
        rd0_seen = rdData0;
        chk("model rdData0", rdData0, m_rd(0));
        chk("model rdData1", rdData1, m_rd(1));
        @(posedge clk);
        m_update();
        #1;
        chk("model memErr0", 32'(memErr0), 32'(m_err[0]));
        chk("model errAddr0", errAddr0, m_eaddr[0]);
        chk("model rdCnt0", 32'(rdCnt0), 32'(m_rc[0]));
        chk("model wrCnt0", 32'(wrCnt0), 32'(m_wc[0]));
        chk("model memErr1", 32'(memErr1), 32'(m_err[1]));
        chk("model errAddr1", errAddr1, m_eaddr[1]);
        chk("model rdCnt1", 32'(rdCnt1), 32'(m_rc[1]));
        chk("model wrCnt1", 32'(wrCnt1), 32'(m_wc[1]));
    endtask

    typedef struct {
        logic        ce, wr, clr;
        logic [31:0] addr, data;
        logic [31:0] rd;
        logic        err;
        logic [31:0] eaddr;
        int          rc, wc;
    } vec_t;

    vec_t tv [15];

    initial begin
        logic [31:0] a, b;
        int sel;

        // Expected values for instance 0 (base 0, 1024 words), applied back to back after reset.
        tv[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 32'h0,    1, 0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0, 32'h0,    2, 0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         32'h0,         1'b0, 32'h0,    3, 0};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'hDEADBEEF,  32'h0,         1'b0, 32'h0,    3, 1};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEADBEEF,  1'b0, 32'h0,    4, 1};
        tv[5]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0011, 32'h12345678,  32'h0,         1'b1, 32'h11,   4, 1};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEADBEEF,  1'b1, 32'h11,   5, 1};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1, 32'h11,   5, 1};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h0,         32'h0,         1'b1, 32'h2000, 5, 1};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 32'h0,    5, 1};
        tv[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0BAD0BAD,  32'h0,         1'b0, 32'h0,    5, 1};
        tv[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEADBEEF,  1'b0, 32'h0,    6, 1};
        tv[12] = '{1'b1, 1'b1, 1'b0, 32'h0000_0FFC, 32'hA5A5A5A5,  32'h0,         1'b0, 32'h0,    6, 2};
        tv[13] = '{1'b1, 1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5A5A5,  1'b0, 32'h0,    7, 2};
        tv[14] = '{1'b1, 1'b0, 1'b0, 32'h0000_0FFE, 32'h0,         32'h0,         1'b1, 32'hFFE,  7, 2};

        rst = 1'b1; memCe = 1'b0; memWr = 1'b0; errClr = 1'b0; memAddr = '0; wtData = '0;
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0; m_eaddr[k] = '0; m_rc[k] = 0; m_wc[k] = 0;
            for (int i = 0; i < 1024; i++) mm[k][i] = '0;
        end
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("reset memErr0", 32'(memErr0), 32'h0);
        chk("reset errAddr0", errAddr0, 32'h0);
        chk("reset rdCnt0", 32'(rdCnt0), 32'h0);
        chk("reset wrCnt0", 32'(wrCnt0), 32'h0);

        for (int i = 0; i < 15; i++) begin
            step(1'b0, tv[i].ce, tv[i].wr, tv[i].clr, tv[i].addr, tv[i].data);
            chk($sformatf("vec%0d rdData", i), rd0_seen, tv[i].rd);
            chk($sformatf("vec%0d memErr", i), 32'(memErr0), 32'(tv[i].err));
            chk($sformatf("vec%0d errAddr", i), errAddr0, tv[i].eaddr);
            chk($sformatf("vec%0d rdCnt", i), 32'(rdCnt0), 32'(tv[i].rc));
            chk($sformatf("vec%0d wrCnt", i), 32'(wrCnt0), 32'(tv[i].wc));
        end

        // Relocated base on instance 1.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("base clr memErr1", 32'(memErr1), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0000_0055);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0);
        chk("base rdData1", rdData1, 32'h0000_0055);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0);
        chk("base low rdData1", rdData1, 32'h0);
        chk("base low memErr1", 32'(memErr1), 32'h1);
        chk("base low errAddr1", errAddr1, 32'h0000_0004);

        // Saturation of the 4-bit read counter, then reset in the middle of a write.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0000 + 32'(4 * i), 32'h0);
        chk("sat rdCnt1", 32'(rdCnt1), 32'hF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h1000_0008, 32'h0000_0077);
        rst = 1'b1; memCe = 1'b1; memWr = 1'b0; memAddr = 32'h1000_0004; #1;
        chk("rst rdData1", rdData1, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_000C, 32'h0000_0099);
        chk("rst rdCnt1", 32'(rdCnt1), 32'h0);
        chk("rst wrCnt1", 32'(wrCnt1), 32'h0);
        chk("rst memErr1", 32'(memErr1), 32'h0);
        chk("rst errAddr1", errAddr1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_000C, 32'h0);
        chk("rst no commit", rdData1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0008, 32'h0);
        chk("rst cleared word", rdData1, 32'h0);

        // Random traffic across both instances' address windows.
        for (int n = 0; n < 600; n++) begin
            b = ($urandom_range(0, 1) == 1) ? 32'h1000_0000 : 32'h0000_0000;
            sel = $urandom_range(0, 9);
            if (sel < 4)       a = b + 32'(4 * $urandom_range(0, 15));
            else if (sel < 6)  a = b + 32'(4 * $urandom_range(1008, 1023));
            else if (sel == 6) a = b + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            else if (sel == 7) a = b + 32'h1000 + 32'(4 * $urandom_range(0, 15));
            else               a = $urandom;
            step(($urandom_range(0, 99) == 0), (sel != 8), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 15) == 0), a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
